// File: rtl/mips32_run_monitor_if.sv
// Snoop bundle from the mips32 core into the run monitor: data-memory writes and PC.
interface mips32_run_monitor_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] pc;

    modport master (output mem_we, mem_addr, mem_wdata, pc);
    modport slave  (input  mem_we, mem_addr, mem_wdata, pc);
endinterface

// File: rtl/mips32_run_monitor.sv
// Run controller / benchmark monitor: core reset hold, run-cycle counter, tohost snoop, timeout.
// Optional PC self-loop halt detector enabled by defining HALT_LOOP_DETECT_EN.
module mips32_run_monitor #(
    parameter int              ADDR_W      = 32,
    parameter int              DATA_W      = 32,
    parameter int              CNT_W       = 32,
    parameter int              RST_CYCLES  = 4,
    parameter int              MAX_CYCLES  = 1000,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR = 32'h0000_FFFC,
    parameter int              LOOP_COUNT  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    mips32_run_monitor_if.slave   snp,
    output logic                  core_reset,
    output logic                  running,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic                  timeout,
    output logic                  halted,
    output logic [DATA_W-1:0]     exit_code,
    output logic [CNT_W-1:0]      cycle_count
);

    typedef enum logic [1:0] {HOLD, RUN, DONE} state_t;

    state_t      state, state_nx;
    logic [31:0] hold_cnt;
    logic        hold_end, tohost_hit, limit_hit, loop_hit;

    assign hold_end   = (RST_CYCLES == 0) || (hold_cnt == 32'(RST_CYCLES - 1));
    assign tohost_hit = (state == RUN) && snp.mem_we && (snp.mem_addr == TOHOST_ADDR);
    assign limit_hit  = (state == RUN) && (cycle_count == CNT_W'(MAX_CYCLES - 1));

`ifdef HALT_LOOP_DETECT_EN
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       loop_cnt;

    // Counts consecutive RUN edges where pc repeats its previous-cycle value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= '0;
            loop_cnt <= '0;
        end else begin
            pc_q <= snp.pc;
            if (state == RUN)
                loop_cnt <= (snp.pc == pc_q) ? loop_cnt + 32'd1 : 32'd0;
        end
    end

    assign loop_hit = (state == RUN) && (snp.pc == pc_q) &&
                      (loop_cnt == 32'(LOOP_COUNT - 1));
`else
    logic unused_pc;
    assign unused_pc = ^snp.pc;
    assign loop_hit  = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= HOLD;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        core_reset = 1'b0;
        running    = 1'b0;
        case (state)
            HOLD: begin
                core_reset = 1'b1;
                if (hold_end) state_nx = RUN;
            end
            RUN: begin
                running = 1'b1;
                if (tohost_hit || loop_hit || limit_hit) state_nx = DONE;
            end
            default: state_nx = DONE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt    <= '0;
            cycle_count <= '0;
            exit_code   <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                HOLD: hold_cnt <= hold_cnt + 32'd1;
                RUN: begin
                    // The edge that leaves RUN is still a run cycle.
                    if (cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);
                    if (tohost_hit) begin
                        exit_code <= snp.mem_wdata;
                        done      <= 1'b1;
                        pass      <= (snp.mem_wdata == DATA_W'(1));
                        fail      <= (snp.mem_wdata != DATA_W'(1));
                    end else if (loop_hit) begin
                        exit_code <= '0;
                        halted    <= 1'b1;
                        pass      <= 1'b1;
                        done      <= 1'b1;
                    end else if (limit_hit) begin
                        timeout   <= 1'b1;
                        fail      <= 1'b1;
                        done      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips32_run_monitor.sv
// Directed bench for mips32_run_monitor: vector table for store/timeout outcomes plus reset sequences.
module tb_mips32_run_monitor;
    localparam int          RSTC   = 4;
    localparam int          MAXC   = 50;
    localparam logic [31:0] TOHOST = 32'h0000_FFFC;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mips32_run_monitor_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    logic        core_reset, running, done, pass, fail, timeout, halted;
    logic [31:0] exit_code, cycle_count;
    logic        z_core_reset, z_running, z_done, z_pass, z_fail, z_timeout, z_halted;
    logic [31:0] z_exit_code, z_cycle_count;

    mips32_run_monitor #(.RST_CYCLES(RSTC), .MAX_CYCLES(MAXC)) dut (
        .clk(clk), .reset(reset), .snp(bus),
        .core_reset(core_reset), .running(running), .done(done), .pass(pass),
        .fail(fail), .timeout(timeout), .halted(halted),
        .exit_code(exit_code), .cycle_count(cycle_count));

    // Boundary instance: no reset hold, one-cycle budget.
    mips32_run_monitor #(.RST_CYCLES(0), .MAX_CYCLES(1)) dut0 (
        .clk(clk), .reset(reset), .snp(bus),
        .core_reset(z_core_reset), .running(z_running), .done(z_done), .pass(z_pass),
        .fail(z_fail), .timeout(z_timeout), .halted(z_halted),
        .exit_code(z_exit_code), .cycle_count(z_cycle_count));

    int n_cmp = 0;
    int n_bad = 0;
    bit pc_hold = 1'b0;

    typedef struct {
        string       nm;
        int          pre;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          e_done, e_pass, e_fail, e_tmo;
        logic [31:0] e_code;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tv[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (!pc_hold) bus.pc = bus.pc + 32'd4;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        bus.mem_we  = 1'b0;
        pc_hold     = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk_outs(input string nm, input vec_t v);
        chk({nm, ".done"},    32'(done),    32'(v.e_done));
        chk({nm, ".pass"},    32'(pass),    32'(v.e_pass));
        chk({nm, ".fail"},    32'(fail),    32'(v.e_fail));
        chk({nm, ".timeout"}, 32'(timeout), 32'(v.e_tmo));
        chk({nm, ".code"},    exit_code,    v.e_code);
        chk({nm, ".count"},   cycle_count,  v.e_cnt);
        chk({nm, ".running"}, 32'(running), 32'(!v.e_done));
        chk({nm, ".halted"},  32'(halted),  32'd0);
    endtask

    initial begin
        tv[0] = '{"pass_store",   20, 1'b1, TOHOST,        32'd1,    1'b1, 1'b1, 1'b0, 1'b0, 32'd1,    32'd21};
        tv[1] = '{"fail_store",   20, 1'b1, TOHOST,        32'h2A,   1'b1, 1'b0, 1'b1, 1'b0, 32'h2A,   32'd21};
        tv[2] = '{"other_addr",   20, 1'b1, 32'h0000_FFF8, 32'd1,    1'b0, 1'b0, 1'b0, 1'b0, 32'd0,    32'd21};
        tv[3] = '{"first_cycle",   0, 1'b1, TOHOST,        32'd0,    1'b1, 1'b0, 1'b1, 1'b0, 32'd0,    32'd1};
        tv[4] = '{"store_at_lim", 49, 1'b1, TOHOST,        32'd1,    1'b1, 1'b1, 1'b0, 1'b0, 32'd1,    32'd50};
        tv[5] = '{"timeout",      49, 1'b0, TOHOST,        32'd1,    1'b1, 1'b0, 1'b1, 1'b1, 32'd0,    32'd50};
        tv[6] = '{"before_lim",   48, 1'b1, TOHOST,        32'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF, 32'd49};

        // Reset state and hold length, plus the zero-hold / one-cycle-budget instance.
        reset = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0; bus.pc = '0;
        #12;
        chk("rst.core_reset", 32'(core_reset), 32'd1);
        chk("rst.running",    32'(running),    32'd0);
        chk("rst.flags",      32'({done, pass, fail, timeout, halted}), 32'd0);
        chk("rst.count",      cycle_count,     32'd0);
        @(negedge clk); reset = 1'b0;
        step(1);
        chk("hold1.core_reset", 32'(core_reset), 32'd1);
        chk("z.run_first_edge", 32'(z_running),  32'd1);
        chk("z.core_reset",     32'(z_core_reset), 32'd0);
        step(1);
        chk("z.timeout", 32'({z_done, z_fail, z_timeout, z_pass}), 32'b1110);
        chk("z.count",   z_cycle_count, 32'd1);
        step(1);
        chk("hold3.core_reset", 32'(core_reset), 32'd1);
        step(1);
        chk("hold4.core_reset", 32'(core_reset), 32'd0);
        chk("hold4.running",    32'(running),    32'd1);
        chk("hold4.count",      cycle_count,     32'd0);
        step(1);
        chk("run1.count",       cycle_count,     32'd1);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            step(RSTC + tv[i].pre);
            bus.mem_we = tv[i].we; bus.mem_addr = tv[i].addr; bus.mem_wdata = tv[i].wdata;
            step(1);
            bus.mem_we = 1'b0;
            chk_outs(tv[i].nm, tv[i]);
            if (tv[i].e_done) begin
                // Stores after DONE must not disturb the frozen result.
                bus.mem_we = 1'b1; bus.mem_addr = TOHOST; bus.mem_wdata = 32'd1;
                step(3);
                bus.mem_we = 1'b0;
                chk_outs({tv[i].nm, ".frozen"}, tv[i]);
                chk({tv[i].nm, ".core_reset"}, 32'(core_reset), 32'd0);
            end
        end

        // Asynchronous reset mid-RUN, then the hold sequence repeats.
        do_reset();
        step(RSTC + 10);
        chk("mid.count", cycle_count, 32'd10);
        #2 reset = 1'b1;
        #1;
        chk("mid.async_count",  cycle_count,     32'd0);
        chk("mid.async_corerst", 32'(core_reset), 32'd1);
        chk("mid.async_running", 32'(running),    32'd0);
        @(negedge clk); reset = 1'b0;
        step(RSTC - 1);
        chk("mid.rehold", 32'(core_reset), 32'd1);
        step(1);
        chk("mid.rerun",  32'(running),    32'd1);

        // Asynchronous reset out of DONE.
        do_reset();
        step(RSTC + 5);
        bus.mem_we = 1'b1; bus.mem_addr = TOHOST; bus.mem_wdata = 32'd7;
        step(1);
        bus.mem_we = 1'b0;
        chk("dn.done", 32'({done, fail}), 32'b11);
        #2 reset = 1'b1;
        #1;
        chk("dn.async_flags", 32'({done, pass, fail, timeout}), 32'd0);
        chk("dn.async_code",  exit_code, 32'd0);
        chk("dn.async_corerst", 32'(core_reset), 32'd1);
        @(negedge clk); reset = 1'b0;

        // PC parked in a self-loop.
        do_reset();
        step(RSTC);
        pc_hold = 1'b1; bus.pc = 32'h40;
        step(12);
`ifdef HALT_LOOP_DETECT_EN
        chk("loop.halted", 32'(halted), 32'd1);
        chk("loop.flags",  32'({done, pass, fail, timeout}), 32'b1100);
        chk("loop.code",   exit_code, 32'd0);
`else
        chk("loop.halted", 32'(halted), 32'd0);
        chk("loop.done",   32'(done),   32'd0);
        step(MAXC);
        chk("loop.timeout", 32'({done, fail, timeout, halted}), 32'b1110);
        chk("loop.count",   cycle_count, 32'd50);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
